// File: rtl/dt_pack.sv
// dt_pack: thresholds the 128x128 distance map into the packed
// 16-bit-per-word binary image and counts the surviving pixels.
module dt_pack #(
    parameter int IMG_PIX = 16384,
    parameter int WORDS   = 1024,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  thr,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        pk_wr,
    output logic [9:0]  pk_addr,
    output logic [15:0] pk_do,
    output logic [14:0] obj_cnt,
    output logic        done
);
    localparam int AW = $clog2(WORDS);
    localparam logic [AW-1:0] LAST = AW'(IMG_PIX / 16 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_word;
    logic [3:0]    r_k;
    logic [15:0]   r_sr;
    logic [14:0]   r_cnt;
    logic [7:0]    r_thr;
    logic          w_cap;
    logic          w_hit;

    // Read data trails the address by one cycle, so pixel k-1 lands at k.
    assign w_cap = (r_state == S_READ && r_k >= 4'(RD_LAT))
                || (r_state == S_DRAIN);
    assign w_hit = (res_di >= r_thr);
    assign obj_cnt = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_k    <= '0;
            r_sr   <= '0;
            r_cnt  <= '0;
            r_thr  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_thr <= thr;
            end
            if (r_state == S_READ) begin
                r_k <= r_k + 4'd1;
            end
            if (w_cap) begin
                r_sr  <= {r_sr[14:0], w_hit};
                r_cnt <= r_cnt + 15'(w_hit);
            end
            if (r_state == S_WRITE && r_word != LAST) begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        res_rd   = 1'b0;
        res_addr = '0;
        pk_wr    = 1'b0;
        pk_addr  = '0;
        pk_do    = '0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_next = S_READ;
            end
            S_READ: begin
                res_rd   = 1'b1;
                res_addr = {r_word, r_k};
                if (r_k == 4'd15) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                pk_wr   = 1'b1;
                pk_addr = r_word;
                pk_do   = r_sr;
                w_next  = (r_word == LAST) ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                done = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dt_pack.sv
// tb_dt_pack: scoreboard bench for dt_pack with a one-cycle-latency
// result RAM model that drives garbage whenever it is not being read.
module tb_dt_pack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  thr = 8'd0;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'd0;
    logic        pk_wr;
    logic [9:0]  pk_addr;
    logic [15:0] pk_do;
    logic [14:0] obj_cnt;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [16384];
    logic [25:0] q [$];

    dt_pack dut (
        .clk      (clk),
        .reset    (reset),
        .thr      (thr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .pk_wr    (pk_wr),
        .pk_addr  (pk_addr),
        .pk_do    (pk_do),
        .obj_cnt  (obj_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
        else        res_di <= 8'($urandom);
    end

    function automatic int min4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    // Square at rows/cols 8..23 with chessboard DT, plus one dot at pixel 16.
    task automatic fill_square();
        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 128; c++) begin
                if (r >= 8 && r <= 23 && c >= 8 && c <= 23)
                    mem[r*128+c] = 8'(min4(r-8, 23-r, c-8, 23-c) + 1);
                else
                    mem[r*128+c] = 8'd0;
            end
        end
        mem[16] = 8'd5;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    endtask

    function automatic logic [15:0] exp_word(int kind, int w);
        int row;
        int g;
        row = w / 8;
        g = w % 8;
        case (kind)
            0: begin
                if (w == 1) return 16'h8000;
                if (row >= 8 && row <= 23 && g == 0) return 16'h00FF;
                if (row >= 8 && row <= 23 && g == 1) return 16'hFF00;
                return 16'h0000;
            end
            1: begin
                if (w == 1) return 16'h8000;
                if (row >= 10 && row <= 21 && g == 0) return 16'h003F;
                if (row >= 10 && row <= 21 && g == 1) return 16'hFC00;
                return 16'h0000;
            end
            2: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic run_frame(input logic [7:0] t, input int kind,
                             input int exp_cnt, input int abort_at,
                             input string nm);
        int n;
        int terr;
        int bad_cyc;
        int done_cyc;
        int rw;
        logic exp_rd;
        logic exp_wr;
        logic [9:0] ea;
        logic [15:0] ed;
        q.delete();
        for (int w = 0; w < 1024; w++) q.push_back({10'(w), exp_word(kind, w)});
        reset = 1'b0;
        repeat (2) @(negedge clk);
        thr = t;
        reset = 1'b1;
        n = 0;
        terr = 0;
        bad_cyc = -1;
        done_cyc = -1;
        while (n < 19000 && done_cyc < 0) begin
            @(negedge clk);
            n++;
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b0;
                #1;
                n_vec++;
                if ({res_rd, res_addr, pk_wr, pk_addr, pk_do, done} !== 43'd0) begin
                    n_err++;
                    $display("FAIL %s abort_outputs got=%h required=0", nm,
                             {res_rd, res_addr, pk_wr, pk_addr, pk_do, done});
                end
                n_vec++;
                if (obj_cnt !== 15'd0) begin
                    n_err++;
                    $display("FAIL %s abort_obj_cnt got=%0d required=0", nm, obj_cnt);
                end
                return;
            end
            rw = (n - 1) % 18;
            exp_rd = (n <= 18432) && (rw < 16);
            exp_wr = (n <= 18432) && (n % 18 == 0);
            if (res_rd !== exp_rd || pk_wr !== exp_wr) begin
                terr++;
                if (bad_cyc < 0) bad_cyc = n;
            end
            if (res_rd === 1'b1 && res_addr !== 14'(((n - 1) / 18) * 16 + rw)) begin
                terr++;
                if (bad_cyc < 0) bad_cyc = n;
            end
            if (pk_wr === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_write addr=%0d required=none", nm, pk_addr);
                end else begin
                    {ea, ed} = q.pop_front();
                    if (pk_addr !== ea || pk_do !== ed) begin
                        n_err++;
                        $display("FAIL %s word got=%0d:%h required=%0d:%h",
                                 nm, pk_addr, pk_do, ea, ed);
                    end
                end
            end
            if (done === 1'b1) done_cyc = n;
        end
        n_vec++;
        if (terr !== 0) begin
            n_err++;
            $display("FAIL %s handshake got=%0d errors (first cycle %0d) required=0",
                     nm, terr, bad_cyc);
        end
        n_vec++;
        if (done_cyc !== 18433) begin
            n_err++;
            $display("FAIL %s done_cycle got=%0d required=18433", nm, done_cyc);
        end
        n_vec++;
        if (obj_cnt !== 15'(exp_cnt)) begin
            n_err++;
            $display("FAIL %s obj_cnt got=%0d required=%0d", nm, obj_cnt, exp_cnt);
        end
        n_vec++;
        if (q.size() !== 0) begin
            n_err++;
            $display("FAIL %s words_missing got=%0d required=0", nm, q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        thr = 8'hA5;
        repeat (3) @(negedge clk);
        n_vec++;
        if (res_rd !== 1'b0 || pk_wr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobes got=%b%b required=00", res_rd, pk_wr);
        end
        n_vec++;
        if (res_addr !== 14'd0 || pk_addr !== 10'd0) begin
            n_err++;
            $display("FAIL reset_addr got=%h/%h required=0/0", res_addr, pk_addr);
        end
        n_vec++;
        if (pk_do !== 16'd0) begin
            n_err++;
            $display("FAIL reset_pk_do got=%h required=0", pk_do);
        end
        n_vec++;
        if (obj_cnt !== 15'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt_done got=%0d/%b required=0/0", obj_cnt, done);
        end
    endtask

    task automatic test_round_trip();
        fill_square();
        run_frame(8'd1, 0, 257, 0, "round_trip");
    endtask

    task automatic test_erosion();
        fill_square();
        run_frame(8'd3, 1, 145, 0, "erosion");
    endtask

    task automatic test_extremes();
        fill_zero();
        run_frame(8'd0, 2, 16384, 0, "thr0_all");
    endtask

    task automatic test_reset_mid_run();
        fill_zero();
        run_frame(8'd1, 3, 0, 5000, "mid_reset");
        run_frame(8'd1, 3, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_erosion();
        test_extremes();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
